// File: rtl/id_inst_queue.sv
// DEPTH-entry {pc, inst} FIFO between IF and the ID decoder, flushed on a taken branch.
// Optional zero-latency bypass on an empty queue when ID_IQ_BYPASS_EN is defined.
module id_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [INST_W-1:0] in_inst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic [CNT_W-1:0]  count_o
);
  localparam int IDX_W = CNT_W - 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [CNT_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic              empty, full, byp_vld;
  logic              push, pop, wr_en, rd_en;
  entry_t            in_ent, head;

  // MSB of each pointer is a wrap bit; equal low bits with differing MSBs means full.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]) && (wr_q[CNT_W-1] != rd_q[CNT_W-1]);

`ifdef ID_IQ_BYPASS_EN
  assign byp_vld = empty & in_valid_i;
`else
  assign byp_vld = 1'b0;
`endif

  assign in_ent      = '{pc: in_pc_i, inst: in_inst_i};
  assign head        = empty ? in_ent : mem_q[rd_q[IDX_W-1:0]];
  assign in_ready_o  = ~full;
  assign out_valid_o = (~empty | byp_vld) & ~flush_i;
  assign out_pc_o    = out_valid_o ? head.pc   : '0;
  assign out_inst_o  = out_valid_o ? head.inst : '0;
  assign count_o     = wr_q - rd_q;

  assign push  = in_valid_i & in_ready_o & ~flush_i;
  assign pop   = out_valid_o & out_ready_i;
  // A pop on an empty queue can only be a bypassed entry: it is consumed, never stored.
  assign wr_en = push & ~(empty & pop);
  assign rd_en = pop & ~empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      rd_d = wr_q;
    end else begin
      if (wr_en) wr_d = wr_q + CNT_W'(1);
      if (rd_en) rd_d = rd_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[IDX_W-1:0]] <= in_ent;
  end
endmodule
